z80_bus_responder: RTL and testbench

Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

---
 rtl/z80_bus_responder.sv | 171 +++++++++++++++++
 tb/tb_z80_bus_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_responder.sv
// z80_bus_responder: memory/I/O target for a Z80 bus with programmable wait states.
//   clk, reset                        : single clock, synchronous active-high reset
//   A, cpu_dout                       : CPU address and write data
//   mreq_n/iorq_n/rd_n/wr_n/m1_n/rfsh_n : Z80 strobes, active-low
//   di, wait_n                        : read data (registered), wait request (from FSM state)
//   ld_en/ld_addr/ld_data             : memory preload port, honoured even in reset
//   m1_count/mem_wr_count/io_wr_count : saturating statistics
//   last_wr_addr/last_wr_data         : most recent committed CPU write
module z80_bus_responder #(
    parameter int unsigned MEM_AW   = 16,
    parameter int unsigned IO_AW    = 8,
    parameter int unsigned WAIT_MEM = 0,
    parameter int unsigned WAIT_IO  = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      A,
    input  logic [7:0]       cpu_dout,
    input  logic             mreq_n,
    input  logic             iorq_n,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic             m1_n,
    input  logic             rfsh_n,
    output logic [7:0]       di,
    output logic             wait_n,
    input  logic             ld_en,
    input  logic [15:0]      ld_addr,
    input  logic [7:0]       ld_data,
    output logic [CNT_W-1:0] m1_count,
    output logic [CNT_W-1:0] mem_wr_count,
    output logic [CNT_W-1:0] io_wr_count,
    output logic [15:0]      last_wr_addr,
    output logic [7:0]       last_wr_data
);

    localparam int unsigned WAIT_MAX  = (WAIT_MEM > WAIT_IO) ? WAIT_MEM : WAIT_IO;
    localparam int unsigned WAIT_CW   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
    localparam int unsigned IO_DEPTH  = 1 << IO_AW;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t             state;
    logic [WAIT_CW-1:0] cnt;

    logic [7:0] mem    [MEM_DEPTH];
    logic [7:0] io_mem [IO_DEPTH];

    // Bus cycle classification
    logic mem_rd, mem_wr, io_rd, io_wr, int_ack;
    logic mem_cls, io_cls, any_cls, cls_none;

    assign mem_rd   = !mreq_n && !rd_n && rfsh_n;
    assign mem_wr   = !mreq_n && !wr_n;
    assign io_rd    = !iorq_n && !rd_n && m1_n;
    assign io_wr    = !iorq_n && !wr_n && m1_n;
    assign int_ack  = !iorq_n && !m1_n;
    assign mem_cls  = mem_rd || mem_wr;
    assign io_cls   = io_rd || io_wr;
    assign any_cls  = mem_cls || io_cls;
    assign cls_none = !(any_cls || int_ack);

    logic [WAIT_CW-1:0] wait_load;
    assign wait_load = mem_cls ? WAIT_CW'(WAIT_MEM) : WAIT_CW'(WAIT_IO);

    // Writes commit only on the cycle the FSM leaves IDLE, never while in reset
    logic idle_exit, commit_mem, commit_io, m1_fetch;
    assign idle_exit  = (state == IDLE) && any_cls && !reset;
    assign commit_mem = idle_exit && mem_wr;
    assign commit_io  = idle_exit && io_wr && !mem_wr;
    assign m1_fetch   = idle_exit && mem_rd && !m1_n;

    assign wait_n = (state != WAIT);

    // Wait-state FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_cls) begin
                        cnt   <= wait_load;
                        state <= (wait_load != '0) ? WAIT : HOLD;
                    end
                end
                WAIT: begin
                    // cnt==1 is the last stalled cycle; leave as it reaches 0
                    if (cnt <= WAIT_CW'(1)) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - WAIT_CW'(1);
                    end
                end
                HOLD: begin
                    if (cls_none) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Memory array: preload is written after the CPU write so it wins on collision
    always_ff @(posedge clk) begin
        if (commit_mem) begin
            mem[A[MEM_AW-1:0]] <= cpu_dout;
        end
        if (ld_en) begin
            mem[ld_addr[MEM_AW-1:0]] <= ld_data;
        end
    end

    // I/O array
    always_ff @(posedge clk) begin
        if (commit_io) begin
            io_mem[A[IO_AW-1:0]] <= cpu_dout;
        end
    end

    // Read data, one-cycle latency, holds when no read class is active
    always_ff @(posedge clk) begin
        if (reset) begin
            di <= 8'h00;
        end else if (mem_rd) begin
            di <= mem[A[MEM_AW-1:0]];
        end else if (io_rd) begin
            di <= io_mem[A[IO_AW-1:0]];
        end else if (int_ack) begin
            di <= 8'hFF;
        end
    end

    // Statistics and last-write capture
    always_ff @(posedge clk) begin
        if (reset) begin
            m1_count     <= '0;
            mem_wr_count <= '0;
            io_wr_count  <= '0;
            last_wr_addr <= 16'h0000;
            last_wr_data <= 8'h00;
        end else begin
            if (m1_fetch && (m1_count != {CNT_W{1'b1}})) begin
                m1_count <= m1_count + CNT_W'(1);
            end
            if (commit_mem && (mem_wr_count != {CNT_W{1'b1}})) begin
                mem_wr_count <= mem_wr_count + CNT_W'(1);
            end
            if (commit_io && (io_wr_count != {CNT_W{1'b1}})) begin
                io_wr_count <= io_wr_count + CNT_W'(1);
            end
            if (commit_mem || commit_io) begin
                last_wr_addr <= A;
                last_wr_data <= cpu_dout;
            end
        end
    end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Bench for z80_bus_responder: three instances sharing one bus.
//   dut a: WAIT_MEM=0, WAIT_IO=1, CNT_W=32
//   dut b: WAIT_MEM=2, WAIT_IO=1, CNT_W=32
//   dut c: WAIT_MEM=3, WAIT_IO=1, CNT_W=2
module tb_z80_bus_responder;

    logic        clk;
    logic        reset;
    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;

    logic [7:0]  di_a, di_b, di_c;
    logic        wait_a, wait_b, wait_c;
    logic [31:0] m1_a, m1_b, mw_a, mw_b, iw_a, iw_b;
    logic [1:0]  m1_c, mw_c, iw_c;
    logic [15:0] lwa_a, lwa_b, lwa_c;
    logic [7:0]  lwd_a, lwd_b, lwd_c;

    logic [7:0]  di_o  [3];
    logic        wait_o[3];
    logic [31:0] m1_o  [3];
    logic [31:0] mw_o  [3];
    logic [31:0] iw_o  [3];
    logic [15:0] lwa_o [3];
    logic [7:0]  lwd_o [3];

    assign di_o[0] = di_a;   assign di_o[1] = di_b;   assign di_o[2] = di_c;
    assign wait_o[0] = wait_a; assign wait_o[1] = wait_b; assign wait_o[2] = wait_c;
    assign m1_o[0] = m1_a;   assign m1_o[1] = m1_b;   assign m1_o[2] = {30'd0, m1_c};
    assign mw_o[0] = mw_a;   assign mw_o[1] = mw_b;   assign mw_o[2] = {30'd0, mw_c};
    assign iw_o[0] = iw_a;   assign iw_o[1] = iw_b;   assign iw_o[2] = {30'd0, iw_c};
    assign lwa_o[0] = lwa_a; assign lwa_o[1] = lwa_b; assign lwa_o[2] = lwa_c;
    assign lwd_o[0] = lwd_a; assign lwd_o[1] = lwd_b; assign lwd_o[2] = lwd_c;

    z80_bus_responder #(.WAIT_MEM(0), .WAIT_IO(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .A(A), .cpu_dout(cpu_dout),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
        .di(di_a), .wait_n(wait_a), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .m1_count(m1_a), .mem_wr_count(mw_a), .io_wr_count(iw_a),
        .last_wr_addr(lwa_a), .last_wr_data(lwd_a));

    z80_bus_responder #(.WAIT_MEM(2), .WAIT_IO(1), .CNT_W(32)) dut_b (
        .clk(clk), .reset(reset), .A(A), .cpu_dout(cpu_dout),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
        .di(di_b), .wait_n(wait_b), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .m1_count(m1_b), .mem_wr_count(mw_b), .io_wr_count(iw_b),
        .last_wr_addr(lwa_b), .last_wr_data(lwd_b));

    z80_bus_responder #(.WAIT_MEM(3), .WAIT_IO(1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .A(A), .cpu_dout(cpu_dout),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n),
        .di(di_c), .wait_n(wait_c), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .m1_count(m1_c), .mem_wr_count(mw_c), .io_wr_count(iw_c),
        .last_wr_addr(lwa_c), .last_wr_data(lwd_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
        logic [15:0] addr;
        logic [7:0]  dout;
        int          hold;
        logic [7:0]  exp_di;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_di;
    int unsigned exp_m1[3], exp_mw[3], exp_iw[3];
    logic [15:0] exp_lwa;
    logic [7:0]  exp_lwd;
    int          cls, steps_n;

    function automatic vec_t mk(logic mq, logic iq, logic rd, logic wr, logic m1, logic rf,
                                logic [15:0] ad, logic [7:0] d, int h, logic [7:0] e);
        vec_t r;
        r.mreq_n = mq; r.iorq_n = iq; r.rd_n = rd; r.wr_n = wr; r.m1_n = m1; r.rfsh_n = rf;
        r.addr = ad; r.dout = d; r.hold = h; r.exp_di = e;
        return r;
    endfunction

    // 0 none, 1 mem-read, 2 mem-write, 3 io-read, 4 io-write, 5 int-ack
    function automatic int cls_of(vec_t v);
        if (!v.mreq_n && !v.rd_n && v.rfsh_n)      return 1;
        else if (!v.mreq_n && !v.wr_n)             return 2;
        else if (!v.iorq_n && !v.rd_n && v.m1_n)   return 3;
        else if (!v.iorq_n && !v.wr_n && v.m1_n)   return 4;
        else if (!v.iorq_n && !v.m1_n)             return 5;
        return 0;
    endfunction

    function automatic int wait_mem_of(int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    // wait_n low for exactly W edges after the access starts
    function automatic logic exp_wait(int i, int c, int k);
        int w;
        w = (c == 1 || c == 2) ? wait_mem_of(i) : (c == 3 || c == 4) ? 1 : 0;
        return (k <= w) ? 1'b0 : 1'b1;
    endfunction

    function automatic int unsigned sat_inc(int unsigned v, int i);
        int unsigned mx;
        mx = (i == 2) ? 32'd3 : 32'hFFFF_FFFF;
        return (v >= mx) ? v : v + 1;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h", name, i, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic mq, input logic iq, input logic rd, input logic wr,
                           input logic m1, input logic rf, input logic [15:0] ad, input logic [7:0] d);
        mreq_n = mq; iorq_n = iq; rd_n = rd; wr_n = wr; m1_n = m1; rfsh_n = rf;
        A = ad; cpu_dout = d;
    endtask

    task automatic bus_idle();
        set_bus(1, 1, 1, 1, 1, 1, 16'h0000, 8'h00);
    endtask

    task automatic check_stats(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, " m1_count"}, i, m1_o[i], exp_m1[i]);
            chk({tag, " mem_wr_count"}, i, mw_o[i], exp_mw[i]);
            chk({tag, " io_wr_count"}, i, iw_o[i], exp_iw[i]);
            chk({tag, " last_wr_addr"}, i, 32'(lwa_o[i]), 32'(exp_lwa));
            chk({tag, " last_wr_data"}, i, 32'(lwd_o[i]), 32'(exp_lwd));
        end
    endtask

    task automatic check_di_all(input string tag, input logic [7:0] e);
        for (int i = 0; i < 3; i++) chk(tag, i, 32'(di_o[i]), 32'(e));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            exp_m1[i] = 0; exp_mw[i] = 0; exp_iw[i] = 0;
        end
        exp_lwa = 16'h0000;
        exp_lwd = 8'h00;
    endtask

    task automatic idle_steps(input int n);
        bus_idle();
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        //              mreq iorq rd wr m1 rfsh addr      dout  hold exp_di
        vecs[0]  = mk(0, 1, 0, 1, 0, 1, 16'h0002, 8'h00, 1, 8'hFD); // opcode fetch
        vecs[1]  = mk(0, 1, 0, 1, 1, 1, 16'h1234, 8'h00, 4, 8'h5A); // mem-read with waits
        vecs[2]  = mk(1, 0, 1, 0, 1, 1, 16'h007F, 8'hA5, 4, 8'h5A); // io-write held 4 cycles
        vecs[3]  = mk(1, 0, 0, 1, 1, 1, 16'h007F, 8'h00, 2, 8'hA5); // io-read
        vecs[4]  = mk(1, 0, 1, 1, 0, 1, 16'h0000, 8'h00, 2, 8'hFF); // int-ack
        vecs[5]  = mk(0, 1, 1, 1, 1, 0, 16'h0003, 8'h00, 2, 8'hFF); // refresh
        for (int j = 0; j < 5; j++)
            vecs[6+j] = mk(0, 1, 1, 0, 1, 1, 16'h0050 + 16'(j), 8'h31 + 8'(j), 1, 8'hFF);
        vecs[11] = mk(0, 1, 0, 1, 1, 1, 16'h0053, 8'h00, 1, 8'h34); // read back written byte
        vecs[12] = mk(1, 0, 0, 1, 1, 1, 16'h127F, 8'h00, 1, 8'hA5); // io port aliasing
        vecs[13] = mk(0, 1, 0, 1, 0, 1, 16'h0003, 8'h00, 2, 8'h0C); // fetch held 2 cycles

        reset = 1'b1;
        ld_en = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00;
        bus_idle();
        clear_model();

        // Preload while in reset
        for (int j = 0; j < 5; j++) begin
            ld_en   = 1'b1;
            ld_addr = (j == 4) ? 16'h1234 : 16'(j);
            case (j)
                0: ld_data = 8'h00;
                1: ld_data = 8'h10;
                2: ld_data = 8'hFD;
                3: ld_data = 8'h0C;
                default: ld_data = 8'h5A;
            endcase
            step();
        end
        ld_en = 1'b0;
        step();

        check_di_all("reset di", 8'h00);
        for (int i = 0; i < 3; i++) chk("reset wait_n", i, 32'(wait_o[i]), 32'd1);
        check_stats("reset");

        reset = 1'b0;
        step();
        exp_di = 8'h00;

        // Table-driven accesses, each starting from IDLE
        for (int v = 0; v < NV; v++) begin
            cls     = cls_of(vecs[v]);
            steps_n = (vecs[v].hold >= 4) ? vecs[v].hold + 1 : 5;
            for (int i = 0; i < 3; i++) begin
                if (cls == 1 && !vecs[v].m1_n) exp_m1[i] = sat_inc(exp_m1[i], i);
                if (cls == 2) exp_mw[i] = sat_inc(exp_mw[i], i);
                if (cls == 4) exp_iw[i] = sat_inc(exp_iw[i], i);
            end
            if (cls == 2 || cls == 4) begin
                exp_lwa = vecs[v].addr;
                exp_lwd = vecs[v].dout;
            end
            for (int k = 1; k <= steps_n; k++) begin
                if (k <= vecs[v].hold)
                    set_bus(vecs[v].mreq_n, vecs[v].iorq_n, vecs[v].rd_n, vecs[v].wr_n,
                            vecs[v].m1_n, vecs[v].rfsh_n, vecs[v].addr, vecs[v].dout);
                else
                    bus_idle();
                exp_q.push_back(vecs[v].exp_di);
                step();
                exp_di = exp_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("vec%0d di step%0d", v, k), i, 32'(di_o[i]), 32'(exp_di));
                    chk($sformatf("vec%0d wait_n step%0d", v, k), i, 32'(wait_o[i]),
                        32'(exp_wait(i, cls, k)));
                end
            end
            check_stats($sformatf("vec%0d", v));
        end

        // Write then read the same index on the very next cycle
        set_bus(0, 1, 1, 0, 1, 1, 16'h0060, 8'h77);
        step();
        set_bus(0, 1, 0, 1, 1, 1, 16'h0060, 8'h00);
        step();
        check_di_all("wr-then-rd di", 8'h77);
        idle_steps(5);
        for (int i = 0; i < 3; i++) exp_mw[i] = sat_inc(exp_mw[i], i);
        exp_lwa = 16'h0060; exp_lwd = 8'h77;
        check_stats("wr-then-rd");

        // Same-cycle preload and CPU write to one index: preload data wins
        ld_en = 1'b1; ld_addr = 16'h0040; ld_data = 8'h11;
        set_bus(0, 1, 1, 0, 1, 1, 16'h0040, 8'h22);
        step();
        ld_en = 1'b0;
        idle_steps(5);
        set_bus(0, 1, 0, 1, 1, 1, 16'h0040, 8'h00);
        step();
        check_di_all("collision di", 8'h11);
        idle_steps(5);
        for (int i = 0; i < 3; i++) exp_mw[i] = sat_inc(exp_mw[i], i);
        exp_lwa = 16'h0040; exp_lwd = 8'h22;
        check_stats("collision");

        // Reset on the first WAIT cycle of a write
        set_bus(0, 1, 1, 0, 1, 1, 16'h0070, 8'h99);
        step();
        chk("pre-reset wait_n", 1, 32'(wait_o[1]), 32'd0);
        chk("pre-reset wait_n", 2, 32'(wait_o[2]), 32'd0);
        reset = 1'b1;
        cpu_dout = 8'hEE;
        step();
        for (int i = 0; i < 3; i++) chk("reset-in-wait wait_n", i, 32'(wait_o[i]), 32'd1);
        check_di_all("reset-in-wait di", 8'h00);
        clear_model();
        check_stats("reset-in-wait");
        reset = 1'b0;
        idle_steps(5);
        set_bus(0, 1, 0, 1, 1, 1, 16'h0070, 8'h00);
        step();
        check_di_all("reset-in-wait mem", 8'h99);
        idle_steps(5);
        check_stats("post-reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
